// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported unified instruction/data memory between the
//   fetch stage (F) and the memory stage (M). One access is in flight at a
//   time; returned read data is captured in output registers and announced
//   with a one-cycle valid pulse. Data accesses win over fetches, but after
//   DATA_BURST_MAX back-to-back data grants with a fetch waiting, the fetch
//   is forced through so the pipeline front end cannot starve.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   PCF, IReqF              fetch address / fetch request
//   InstrF, IValidF         registered instruction, one-cycle update pulse
//   ALUOutM, WriteDataM     data address / store data
//   MemWriteM, DReqM        store qualifier / data request
//   ReadDataM, DValidM      registered load data, one-cycle completion pulse
//   StallFetch, StallMem    stall requests for the hazard unit
//   mem_req .. mem_wdata    memory request, held until mem_ready
//   mem_rdata, mem_ready    memory read data and access-complete strobe
module mem_arbiter #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int DATA_BURST_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] PCF,
   input  logic          IReqF,
   output logic [DW-1:0] InstrF,
   output logic          IValidF,
   input  logic [AW-1:0] ALUOutM,
   input  logic [DW-1:0] WriteDataM,
   input  logic          MemWriteM,
   input  logic          DReqM,
   output logic [DW-1:0] ReadDataM,
   output logic          DValidM,
   output logic          StallFetch,
   output logic          StallMem,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   localparam logic [3:0] BURST_MAX = 4'(DATA_BURST_MAX);

   state_t        state_q, state_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] instr_q, instr_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          ivalid_q, ivalid_d;
   logic          dvalid_q, dvalid_d;
   logic [3:0]    starve_cnt_q, starve_cnt_d;
   logic          fetch_grant;

   // Fetch wins when it has waited through a full data burst, or when no
   // data request competes with it.
   assign fetch_grant = IReqF && ((starve_cnt_q == BURST_MAX) || !DReqM);

   always_comb begin
      // NOTE: every signal gets a default here so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      instr_d      = instr_q;
      rdata_d      = rdata_q;
      starve_cnt_d = starve_cnt_q;
      ivalid_d     = 1'b0;
      dvalid_d     = 1'b0;

      case (state_q)
         IDLE: begin
            // mem_ready is deliberately ignored here.
            if (fetch_grant) begin
               state_d    = BUSY_I;
               mem_addr_d = PCF;
               mem_we_d   = 1'b0;
            end else if (DReqM) begin
               state_d     = BUSY_D;
               mem_addr_d  = ALUOutM;
               mem_we_d    = MemWriteM;
               mem_wdata_d = WriteDataM;
            end
         end
         BUSY_I: begin
            if (mem_ready) begin
               state_d      = IDLE;
               instr_d      = mem_rdata;
               ivalid_d     = 1'b1;
               starve_cnt_d = '0;
            end
         end
         BUSY_D: begin
            if (mem_ready) begin
               state_d  = IDLE;
               dvalid_d = 1'b1;
               if (!mem_we_q) rdata_d = mem_rdata;
               // Count data grants only while a fetch is actually waiting.
               if (IReqF)
                  starve_cnt_d = (starve_cnt_q == BURST_MAX) ? starve_cnt_q
                                                            : starve_cnt_q + 4'd1;
               else
                  starve_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Registered so mem_req is high exactly for the cycles spent in BUSY_*.
      mem_req_d = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples its _d value from before this edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         instr_q      <= '0;
         rdata_q      <= '0;
         ivalid_q     <= 1'b0;
         dvalid_q     <= 1'b0;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         instr_q      <= instr_d;
         rdata_q      <= rdata_d;
         ivalid_q     <= ivalid_d;
         dvalid_q     <= dvalid_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign InstrF     = instr_q;
   assign IValidF    = ivalid_q;
   assign ReadDataM  = rdata_q;
   assign DValidM    = dvalid_q;
   assign StallFetch = IReqF & ~ivalid_q;
   assign StallMem   = DReqM & ~dvalid_q;

endmodule
